// File: rtl/serial_slt_unit_if.sv
// Operand/result handshake bundle for the serial compare unit.
// master drives operands and consumes the result; slave is the unit.
interface serial_slt_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/serial_slt_unit.sv
// Multi-cycle SLT/SLTU/SEQ/SLE comparator, CHUNK bits per clock,
// LSB chunk first; each higher differing chunk overrides the decision.
module serial_slt_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    serial_slt_unit_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] M_SEQ = 2'b10;
    localparam logic [1:0] M_SLE = 2'b11;

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_slt_unit: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       mode_q;
    logic             lt_q;
    logic             eq_q;
    logic             res_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             lt_d;
    logic             eq_d;
    logic             last;
    logic [WIDTH-1:0] msb_flip;

    // Signed modes flip the sign bits so the chunk walk stays unsigned.
    assign msb_flip = {(bus.mode[1] == bus.mode[0]), {(WIDTH-1){1'b0}}};
    assign last     = (cnt_q == CW'(N - 1));
    assign a_chunk  = a_q[CHUNK-1:0];
    assign b_chunk  = b_q[CHUNK-1:0];

    always_comb begin
        lt_d = lt_q;
        eq_d = eq_q;
        if (a_chunk != b_chunk) begin
            lt_d = (a_chunk < b_chunk);
            eq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            res_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a ^ msb_flip;
                        b_q     <= bus.b ^ msb_flip;
                        mode_q  <= bus.mode;
                        lt_q    <= (bus.mode == M_SLE);
                        eq_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift down so the live chunk is always at bit 0.
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    lt_q  <= lt_d;
                    eq_q  <= eq_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        res_q       <= (mode_q == M_SEQ) ? eq_d : lt_d;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = {{(WIDTH-1){1'b0}}, res_q};
endmodule
